// File: rtl/frame_capture_ctrl_pkg.sv
// rtl/frame_capture_ctrl_pkg.sv - shared state encoding, pixel formats and default geometry
package frame_capture_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_VBLANK  = 2'd2,
      ST_CAPTURE = 2'd3
   } state_e;

   localparam logic FMT_RGB444 = 1'b0;
   localparam logic FMT_RGB565 = 1'b1;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_ADDR_W   = 17;
   localparam int DEF_DEPTH    = 76800;
   localparam int DEF_CNT_W    = 11;

   // Low-bit mask a coordinate must clear to be kept; codes 2 and 3 both mean 1:4.
   function automatic logic [1:0] dec_mask(input logic [1:0] dec);
      case (dec)
         2'd0:    dec_mask = 2'b00;
         2'd1:    dec_mask = 2'b01;
         default: dec_mask = 2'b11;
      endcase
   endfunction

endpackage

// File: rtl/frame_capture_ctrl_pixel_pack.sv
// rtl/frame_capture_ctrl_pixel_pack.sv - byte-pair assembly and format mapping
module rgb_pixel_pack
   import frame_capture_ctrl_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        active_i,
   input  logic        clear_i,
   input  logic        href_i,
   input  logic        href_rise_i,
   input  logic [7:0]  byte_i,
   input  logic        fmt_i,
   output logic        pix_valid_o,
   output logic [15:0] pix_data_o
);

   logic       phase_q;
   logic [7:0] b1_q;
   logic       phase_eff;

   // The first byte of a line must land in phase 0 even if a stray odd byte was seen before.
   assign phase_eff   = href_rise_i ? 1'b0 : phase_q;
   assign pix_valid_o = active_i && href_i && phase_eff;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         phase_q <= 1'b0;
         b1_q    <= 8'h00;
      end else if (clear_i || !active_i) begin
         phase_q <= 1'b0;
      end else if (href_i) begin
         if (!phase_eff) begin
            b1_q    <= byte_i;
            phase_q <= 1'b1;
         end else begin
            phase_q <= 1'b0;
         end
      end
   end

   always_comb begin
      pix_data_o = {b1_q, byte_i};
      case (fmt_i)
         FMT_RGB444: pix_data_o = {4'h0, b1_q[7:4], b1_q[2:0], byte_i[7], byte_i[4:1]};
         FMT_RGB565: pix_data_o = {b1_q, byte_i};
         default:    pix_data_o = {b1_q, byte_i};
      endcase
   end

endmodule

// File: rtl/frame_capture_ctrl.sv
// rtl/frame_capture_ctrl.sv - camera byte stream to framebuffer writes with decimation and geometry checks
module frame_capture_ctrl
   import frame_capture_ctrl_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vsync,
   input  logic              href,
   input  logic [7:0]        D_data,
   input  logic              enable,
   input  logic              continuous,
   input  logic              start_capture,
   input  logic              fmt,
   input  logic [1:0]        dec,
   output logic              write_enable,
   output logic [ADDR_W-1:0] save_address,
   output logic [15:0]       save_data,
   output logic              busy,
   output logic              frame_done,
   output logic              line_err,
   output logic              frame_err,
   output logic              overflow
);

   logic              vs_q, vs_p_q, hr_q, hr_p_q;
   logic [7:0]        d_q;
   state_e            state_q;
   logic [CNT_W-1:0]  x_q, y_q;
   logic [ADDR_W-1:0] addr_q, save_address_q;
   logic              full_q;
   logic [15:0]       save_data_q;
   logic              fmt_q;
   logic [1:0]        dec_q;
   logic              write_enable_q, busy_q, frame_done_q;
   logic              line_err_q, frame_err_q, overflow_q;

   logic              vs_rise, vs_fall, hr_rise, hr_fall;
   logic              capturing, pack_clear, pix_valid, keep;
   logic [1:0]        keep_mask;
   logic [15:0]       pix_data;

   assign vs_rise    = vs_q && !vs_p_q;
   assign vs_fall    = !vs_q && vs_p_q;
   assign hr_rise    = hr_q && !hr_p_q;
   assign hr_fall    = !hr_q && hr_p_q;
   assign capturing  = (state_q == ST_CAPTURE) && enable;
   assign pack_clear = (state_q == ST_VBLANK) && vs_fall;
   assign keep_mask  = dec_mask(dec_q);
   assign keep       = ((x_q[1:0] & keep_mask) == 2'b00) && ((y_q[1:0] & keep_mask) == 2'b00);

   rgb_pixel_pack u_pack (
      .clk_i       (clk),
      .rst_ni      (reset),
      .active_i    (capturing),
      .clear_i     (pack_clear),
      .href_i      (hr_q),
      .href_rise_i (hr_rise),
      .byte_i      (d_q),
      .fmt_i       (fmt_q),
      .pix_valid_o (pix_valid),
      .pix_data_o  (pix_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vs_q           <= 1'b0;
         vs_p_q         <= 1'b0;
         hr_q           <= 1'b0;
         hr_p_q         <= 1'b0;
         d_q            <= 8'h00;
         state_q        <= ST_IDLE;
         x_q            <= '0;
         y_q            <= '0;
         addr_q         <= '0;
         save_address_q <= '0;
         full_q         <= 1'b0;
         save_data_q    <= 16'h0000;
         fmt_q          <= FMT_RGB444;
         dec_q          <= 2'd0;
         write_enable_q <= 1'b0;
         busy_q         <= 1'b0;
         frame_done_q   <= 1'b0;
         line_err_q     <= 1'b0;
         frame_err_q    <= 1'b0;
         overflow_q     <= 1'b0;
      end else begin
         vs_q           <= vsync;
         hr_q           <= href;
         d_q            <= D_data;
         vs_p_q         <= vs_q;
         hr_p_q         <= hr_q;
         write_enable_q <= 1'b0;
         frame_done_q   <= 1'b0;

         if (!enable) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (continuous || start_capture) begin
                     state_q        <= ST_ARM;
                     busy_q         <= 1'b1;
                     line_err_q     <= 1'b0;
                     frame_err_q    <= 1'b0;
                     overflow_q     <= 1'b0;
                     addr_q         <= '0;
                     save_address_q <= '0;
                     full_q         <= 1'b0;
                  end
               end
               // Waiting for blanking first keeps a mid-frame arm from capturing a partial frame.
               ST_ARM: begin
                  if (vs_q) state_q <= ST_VBLANK;
               end
               ST_VBLANK: begin
                  if (vs_fall) begin
                     state_q <= ST_CAPTURE;
                     x_q     <= '0;
                     y_q     <= '0;
                     addr_q  <= '0;
                     full_q  <= 1'b0;
                     fmt_q   <= fmt;
                     dec_q   <= dec;
                  end
               end
               ST_CAPTURE: begin
                  if (pix_valid) begin
                     x_q <= x_q + CNT_W'(1);
                     if (keep) begin
                        if (full_q) begin
                           overflow_q <= 1'b1;
                        end else begin
                           write_enable_q <= 1'b1;
                           save_address_q <= addr_q;
                           save_data_q    <= pix_data;
                           if (addr_q == ADDR_W'(DEPTH - 1)) full_q <= 1'b1;
                           else                               addr_q <= addr_q + ADDR_W'(1);
                        end
                     end
                  end
                  if (hr_fall) begin
                     if (x_q != CNT_W'(H_ACTIVE)) line_err_q <= 1'b1;
                     y_q <= y_q + CNT_W'(1);
                     x_q <= '0;
                  end
                  if (vs_rise) begin
                     frame_done_q <= 1'b1;
                     if (y_q != CNT_W'(V_ACTIVE)) frame_err_q <= 1'b1;
                     if (continuous) begin
                        state_q <= ST_VBLANK;
                     end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                     end
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign write_enable = write_enable_q;
   assign save_address = save_address_q;
   assign save_data    = save_data_q;
   assign busy         = busy_q;
   assign frame_done   = frame_done_q;
   assign line_err     = line_err_q;
   assign frame_err    = frame_err_q;
   assign overflow     = overflow_q;

endmodule

// File: doc/frame_capture_ctrl.md
Name: frame_capture_ctrl

Overview:
- Parametrised successor to the fixed-format camera byte-capture path.
- Runs in the camera pixel-clock domain and turns OV7670 vsync/href/D_data bytes into linear framebuffer writes.
- Adds selectable pixel format, power-of-two decimation, single-shot or continuous capture, address saturation, and line/frame geometry checking.
- Sits between the camera pins and the write port of the framebuffer RAM; frame status goes to the control FSM.

Parameters:
- H_ACTIVE, 640, expected pixels per line (two bytes each).
- V_ACTIVE, 480, expected lines per frame.
- ADDR_W, 17, framebuffer address width.
- DEPTH, 76800, framebuffer words; last valid address is DEPTH-1.
- CNT_W, 11, width of x/y counters.

Ports:
- clk  in  1  capture clock (connected to camera pclk); all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- vsync  in  1  camera vsync, active high during vertical blanking.
- href  in  1  camera line-valid.
- D_data  in  8  camera byte.
- enable  in  1  capture enable; low aborts immediately.
- continuous  in  1  1 = every frame, 0 = one frame per start_capture.
- start_capture  in  1  single-cycle arm pulse.
- fmt  in  1  0 = RGB565→RGB444 (zero-extended to 16 bits), 1 = RGB565 passthrough.
- dec  in  2  decimation: 0 = 1:1, 1 = 1:2, 2 = 1:4; 3 is treated as 1:4.
- write_enable  out  1  framebuffer write strobe.
- save_address  out  ADDR_W  write address.
- save_data  out  16  write data.
- busy  out  1  high outside IDLE.
- frame_done  out  1  one-cycle pulse at the end of a captured frame.
- line_err  out  1  sticky: a line's pixel count was not H_ACTIVE.
- frame_err  out  1  sticky: the frame's line count was not V_ACTIVE.
- overflow  out  1  sticky: a write was attempted beyond DEPTH-1.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, byte phase 0.
- Input stage: vsync, href and D_data are registered once (stage S0). Edges are detected on the S0 values.
- State machine:
  - IDLE: leave when enable=1 and (continuous=1 or start_capture=1); go to ARM. Clear the sticky flags and the address.
  - ARM: wait for S0 vsync=1, then go to VBLANK. This guarantees capture begins on a whole frame.
  - VBLANK: on S0 vsync falling edge go to CAPTURE; x, y, address and byte phase are set to 0.
  - CAPTURE, per line:
    - href rising edge sets byte phase to 0.
    - Each href=1 cycle toggles the phase; phase 0 latches the first byte, phase 1 completes a pixel.
    - href falling edge: line_err is set if x != H_ACTIVE; then y increments and x clears.
  - CAPTURE, frame end: on vsync rising edge, frame_done pulses and frame_err is set if y != V_ACTIVE.
    - If continuous=1 and enable=1, go to VBLANK.
    - Otherwise go to IDLE.
- enable=0 in any state: go to IDLE next cycle, with no frame_done and no further writes.
- start_capture outside IDLE is ignored.
- Pixel keep rule: keep when x mod 2^d = 0 and y mod 2^d = 0 (d = min(dec,2)). x increments on every completed pixel, kept or not.
- Data mapping, with b1 = first byte and b2 = second byte:
  - fmt=0: save_data = {4'h0, b1[7:4], b1[2:0], b2[7], b2[4:1]}.
  - fmt=1: save_data = {b1, b2}.
- Write timing: a kept pixel completed at S0 edge N produces write_enable=1 for exactly the cycle after edge N+1, with save_address and save_data valid in that cycle. The address then increments.
- Latency: 2 clk from the second byte at the pins to the write strobe.
- Saturation: when the address is DEPTH-1 and another kept pixel arrives, no write occurs, the address holds, and overflow is set.
- The fmt and dec inputs are sampled on entering CAPTURE and held for the frame.
- Sticky flags hold until the next IDLE→ARM transition.

Decomposition:
- Shared package holds the state encoding (IDLE, ARM, VBLANK, CAPTURE), FMT_RGB444 and FMT_RGB565, and the default geometry constants.
- Natural sub-module: rgb_pixel_pack, which does byte-phase assembly and format mapping and emits a pixel-valid strobe. The FSM, counters and address generation stay in the top.

Test Plan:
- Reset asserted mid-CAPTURE (reset=0) → all outputs 0 immediately; after release, busy=0.
- continuous=1, fmt=0, dec=0, 640x480 frame with bytes 0xF8,0x1F → 307200 writes, data 0x0F0F, last address 307199 with DEPTH=307200, one frame_done, no error flags.
- dec=1, DEPTH=76800, full frame → 76800 writes with addresses 0..76799; the pixel at x=1 or y=1 is never written.
- Single-shot, start_capture pulsed mid-frame → no writes until the next full frame; exactly one frame_done; busy=0 afterwards; a second frame is ignored.
- Line of 639 pixels → line_err=1; frame of 479 lines → frame_err=1; both clear on the next arm.
- DEPTH=1000, dec=0 → 1000 writes, then overflow=1 and save_address holds at 999.
